// File: rtl/uart_bus_pkg.sv
// Shared constants, state encoding and a byte-shift helper for the UART bus master.
package uart_bus_pkg;

  // Command and response bytes on the host link
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RESP_ACK  = 8'h06;

  // Main sequencer states; everything except ST_IDLE counts as busy
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_WRITE,
    ST_READ,
    ST_RESP,
    ST_TXWAIT
  } state_t;

  // Little-endian field assembly: newest byte enters at the top
  function automatic logic [31:0] shift_in_byte(input logic [31:0] cur, input logic [7:0] b);
    return {b, cur[31:8]};
  endfunction

endpackage

// File: rtl/uart_resp_ser.sv
// Response serializer: holds up to four response bytes and hands them to the
// UART transmitter one at a time, least significant byte first.
module uart_resp_ser
  import uart_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_load_len4,
  input  logic [31:0] i_load_data,
  input  logic        i_in_resp,
  input  logic        i_tx_busy,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_start,
  output logic        o_fire,
  output logic        o_done
);

  logic [31:0] r_buf;
  logic [2:0]  r_remain;
  logic [7:0]  r_tx_data;
  logic        r_tx_start;

  // A byte leaves only while the sequencer is in RESP and the transmitter is free
  assign o_fire     = i_in_resp & ~i_tx_busy;
  assign o_done     = (r_remain == 3'd0);
  assign o_tx_data  = r_tx_data;
  assign o_tx_start = r_tx_start;

  // Load a fresh response or pop the next byte into the transmit register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_buf      <= '0;
      r_remain   <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
    end else begin
      r_tx_start <= o_fire;
      if (i_load) begin
        r_buf    <= i_load_data;
        r_remain <= i_load_len4 ? 3'd4 : 3'd1;
      end else if (o_fire) begin
        r_tx_data <= r_buf[7:0];
        r_buf     <= {8'h00, r_buf[31:8]};
        r_remain  <= r_remain - 3'd1;
      end
    end
  end

endmodule

// File: rtl/uart_bus_master.sv
// UART-driven bus initiator: parses write/read frames from the host byte
// stream, performs one bus access per frame and returns an ACK or read data.
module uart_bus_master
  import uart_bus_pkg::*;
#(
  parameter int READ_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 1040000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i,
  output logic        mem_oe_n,
  output logic        mem_we_n,
  output logic        busy_o,
  output logic [1:0]  err_o
);

  // Counter widths; the timeout counter never needs to exceed TIMEOUT_CYCLES-1
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) + 1 : 1;
  localparam int RD_W = (READ_CYCLES > 1) ? $clog2(READ_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RD_W-1:0] RD_LAST = RD_W'(READ_CYCLES - 1);

  state_t          r_state;
  state_t          w_state_next;
  logic            r_is_write;
  logic [1:0]      r_byte_cnt;
  logic [TO_W-1:0] r_to_cnt;
  logic [RD_W-1:0] r_rd_cnt;
  logic [31:0]     r_addr_sh;
  logic [31:0]     r_data_sh;
  logic [31:0]     r_mem_addr;
  logic [31:0]     r_mem_data;
  logic            r_oe_n;
  logic            r_we_n;
  logic            r_busy;
  logic [1:0]      r_err;

  logic            w_start;
  logic            w_accept;
  logic            w_timeout;
  logic            w_overrun;
  logic            w_load;
  logic            w_load_len4;
  logic [31:0]     w_load_data;
  logic            w_in_frame;
  logic            w_ser_fire;
  logic            w_ser_done;

  assign w_in_frame = (r_state == ST_ADDR) || (r_state == ST_DATA);

  assign mem_addr_o = r_mem_addr;
  assign mem_data_o = r_mem_data;
  assign mem_oe_n   = r_oe_n;
  assign mem_we_n   = r_we_n;
  assign busy_o     = r_busy;
  assign err_o      = r_err;

  // Next-state and per-cycle event decode for the frame sequencer
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_accept     = 1'b0;
    w_timeout    = 1'b0;
    w_overrun    = 1'b0;
    w_load       = 1'b0;
    w_load_len4  = 1'b0;
    w_load_data  = '0;
    case (r_state)
      ST_IDLE: begin
        // Non-command bytes fall through silently
        if (rx_valid && (rx_data == CMD_WRITE || rx_data == CMD_READ)) begin
          w_start      = 1'b1;
          w_state_next = ST_ADDR;
        end
      end
      ST_ADDR: begin
        // A byte arriving on the timeout cycle wins over the timeout
        if (rx_valid) begin
          w_accept = 1'b1;
          if (r_byte_cnt == 2'd3) begin
            w_state_next = r_is_write ? ST_DATA : ST_READ;
          end
        end else if (r_to_cnt == TO_LAST) begin
          w_timeout    = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (rx_valid) begin
          w_accept = 1'b1;
          if (r_byte_cnt == 2'd3) begin
            w_state_next = ST_WRITE;
          end
        end else if (r_to_cnt == TO_LAST) begin
          w_timeout    = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      ST_WRITE: begin
        w_overrun    = rx_valid;
        w_load       = 1'b1;
        w_load_data  = {24'h000000, RESP_ACK};
        w_state_next = ST_RESP;
      end
      ST_READ: begin
        w_overrun = rx_valid;
        // Read data is captured on the final strobe cycle
        if (r_rd_cnt == RD_LAST) begin
          w_load       = 1'b1;
          w_load_len4  = 1'b1;
          w_load_data  = mem_data_i;
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        w_overrun = rx_valid;
        if (w_ser_fire) begin
          w_state_next = ST_TXWAIT;
        end
      end
      ST_TXWAIT: begin
        // Single cycle that rides over the transmitter's busy latency
        w_overrun    = rx_valid;
        w_state_next = w_ser_done ? ST_IDLE : ST_RESP;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State register plus strobes and busy, all derived from the next state
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_we_n  <= 1'b1;
      r_oe_n  <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next != ST_IDLE);
      r_we_n  <= (w_state_next != ST_WRITE);
      r_oe_n  <= (w_state_next != ST_READ);
    end
  end

  // Frame bookkeeping: command latch, byte count, inter-byte timeout, read strobe length
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_is_write <= 1'b0;
      r_byte_cnt <= '0;
      r_to_cnt   <= '0;
      r_rd_cnt   <= '0;
    end else begin
      if (w_start) begin
        r_is_write <= (rx_data == CMD_WRITE);
        r_byte_cnt <= '0;
        r_to_cnt   <= '0;
      end else if (w_accept) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        r_to_cnt   <= '0;
      end else if (w_in_frame && !w_timeout) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
      if (r_state == ST_READ) begin
        r_rd_cnt <= r_rd_cnt + 1'b1;
      end else begin
        r_rd_cnt <= '0;
      end
    end
  end

  // Field assembly; the bus registers change only when a frame completes
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_addr_sh  <= '0;
      r_data_sh  <= '0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else begin
      if (w_accept && r_state == ST_ADDR) begin
        r_addr_sh <= shift_in_byte(r_addr_sh, rx_data);
      end
      if (w_accept && r_state == ST_DATA) begin
        r_data_sh <= shift_in_byte(r_data_sh, rx_data);
      end
      if (r_state == ST_ADDR && w_state_next == ST_READ) begin
        r_mem_addr <= shift_in_byte(r_addr_sh, rx_data);
      end
      if (r_state == ST_DATA && w_state_next == ST_WRITE) begin
        r_mem_addr <= r_addr_sh;
        r_mem_data <= shift_in_byte(r_data_sh, rx_data);
      end
    end
  end

  // Sticky error flags {overrun, timeout}
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_err <= 2'b00;
    end else begin
      if (w_overrun) begin
        r_err[1] <= 1'b1;
      end
      if (w_timeout) begin
        r_err[0] <= 1'b1;
      end
    end
  end

  uart_resp_ser u_resp_ser (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_load_len4 (w_load_len4),
    .i_load_data (w_load_data),
    .i_in_resp   (r_state == ST_RESP),
    .i_tx_busy   (tx_busy),
    .o_tx_data   (tx_data),
    .o_tx_start  (tx_start),
    .o_fire      (w_ser_fire),
    .o_done      (w_ser_done)
  );

endmodule

// File: tb/tb_uart_bus_master.sv
// Bench for uart_bus_master: drives host frames, models a transmitter with a
// configurable busy time, and checks bus strobes and response bytes.
module tb_uart_bus_master;

  localparam int RDC = 2;
  localparam int TOC = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [31:0] mem_data_i = 32'h0;
  logic        mem_oe_n;
  logic        mem_we_n;
  logic        busy_o;
  logic [1:0]  err_o;

  int n_checks = 0;
  int n_fails  = 0;

  // Bus / transmitter observation
  int          cyc = 0;
  int          we_cycles = 0;
  int          oe_cycles = 0;
  int          oe_runs = 0;
  int          both_low = 0;
  logic [31:0] we_addr = 32'h0;
  logic [31:0] we_data = 32'h0;
  logic [31:0] oe_addr = 32'h0;
  logic        prev_oe_n = 1'b1;
  logic [7:0]  tx_q[$];
  int          tx_t[$];
  int          busy_hold = 0;
  int          busy_left = 0;

  // Reference view of the bus registers
  logic [31:0] m_addr = 32'h0;
  logic [31:0] m_wr_data = 32'h0;

  typedef logic [7:0] byte_q_t[$];

  uart_bus_master #(
    .READ_CYCLES    (RDC),
    .TIMEOUT_CYCLES (TOC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .mem_addr_o (mem_addr_o),
    .mem_data_o (mem_data_o),
    .mem_data_i (mem_data_i),
    .mem_oe_n   (mem_oe_n),
    .mem_we_n   (mem_we_n),
    .busy_o     (busy_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  // Expected response bytes from the frame rules
  function automatic byte_q_t model_resp(input bit is_wr, input logic [31:0] rdata);
    byte_q_t q;
    if (is_wr) q.push_back(8'h06);
    else for (int i = 0; i < 4; i++) q.push_back(8'((rdata >> (8 * i)) & 32'hFF));
    return q;
  endfunction

  // Monitor and transmitter model, sampled 1 ns after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!mem_we_n) begin
        we_cycles++;
        we_addr = mem_addr_o;
        we_data = mem_data_o;
      end
      if (!mem_oe_n) begin
        oe_cycles++;
        oe_addr = mem_addr_o;
        if (prev_oe_n) oe_runs++;
      end
      prev_oe_n = mem_oe_n;
      if (!mem_we_n && !mem_oe_n) both_low++;
      if (tx_start) begin
        tx_q.push_back(tx_data);
        tx_t.push_back(cyc);
        if (busy_hold > 0) begin
          tx_busy = 1'b1;
          busy_left = busy_hold - 1;
        end
      end else if (busy_left > 0) begin
        busy_left--;
      end else begin
        tx_busy = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input bit is_wr, input logic [31:0] addr, input logic [31:0] data);
    send_byte(is_wr ? 8'h57 : 8'h52);
    for (int i = 0; i < 4; i++) send_byte(8'((addr >> (8 * i)) & 32'hFF));
    if (is_wr) for (int i = 0; i < 4; i++) send_byte(8'((data >> (8 * i)) & 32'hFF));
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy_o !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fails++;
      $display("FAIL %s_idle busy_o=%b after %0d cycles, required 0", tag, busy_o, n);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({mem_oe_n, mem_we_n} !== 2'b11) begin
      n_fails++;
      $display("FAIL reset_strobes oe_n/we_n=%b, required 11", {mem_oe_n, mem_we_n});
    end
    n_checks++;
    if ({mem_addr_o, mem_data_o} !== 64'h0) begin
      n_fails++;
      $display("FAIL reset_bus addr=%h data=%h, required 0", mem_addr_o, mem_data_o);
    end
    n_checks++;
    if ({tx_data, tx_start} !== 9'h0) begin
      n_fails++;
      $display("FAIL reset_tx tx_data=%h tx_start=%b, required 0", tx_data, tx_start);
    end
    n_checks++;
    if ({busy_o, err_o} !== 3'b000) begin
      n_fails++;
      $display("FAIL reset_status busy=%b err=%b, required 0/00", busy_o, err_o);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    int we0 = we_cycles;
    int oe0 = oe_cycles;
    byte_q_t exp = model_resp(1'b1, 32'h0);
    tx_q.delete();
    tx_t.delete();
    send_frame(1'b1, 32'h80000000, 32'hDEADBEEF);
    wait_idle("write");
    m_addr = 32'h80000000;
    m_wr_data = 32'hDEADBEEF;
    n_checks++;
    if (we_cycles - we0 != 1) begin
      n_fails++;
      $display("FAIL write_we_len we_n low %0d cycles, required 1", we_cycles - we0);
    end
    n_checks++;
    if (we_addr !== m_addr || we_data !== m_wr_data) begin
      n_fails++;
      $display("FAIL write_bus addr=%h data=%h, required %h %h", we_addr, we_data, m_addr, m_wr_data);
    end
    n_checks++;
    if (oe_cycles != oe0) begin
      n_fails++;
      $display("FAIL write_no_oe oe low %0d cycles, required 0", oe_cycles - oe0);
    end
    n_checks++;
    if (tx_q.size() != 1 || tx_q[0] !== exp[0]) begin
      n_fails++;
      $display("FAIL write_resp got %0d bytes first=%h, required 1 byte %h", tx_q.size(),
               (tx_q.size() > 0) ? tx_q[0] : 8'hxx, exp[0]);
    end
  endtask

  task automatic test_read_busy();
    int oe0 = oe_cycles;
    int or0 = oe_runs;
    byte_q_t exp = model_resp(1'b0, 32'h00000041);
    tx_q.delete();
    tx_t.delete();
    busy_hold = 50;
    mem_data_i = 32'h00000041;
    send_frame(1'b0, 32'hBFD003F8, 32'h0);
    wait_idle("read");
    busy_hold = 0;
    m_addr = 32'hBFD003F8;
    n_checks++;
    if (oe_cycles - oe0 != RDC || oe_runs - or0 != 1) begin
      n_fails++;
      $display("FAIL read_oe_len oe low %0d cycles in %0d pulses, required %0d in 1",
               oe_cycles - oe0, oe_runs - or0, RDC);
    end
    n_checks++;
    if (oe_addr !== m_addr) begin
      n_fails++;
      $display("FAIL read_addr addr=%h, required %h", oe_addr, m_addr);
    end
    n_checks++;
    if (tx_q.size() != exp.size()) begin
      n_fails++;
      $display("FAIL read_resp_len got %0d bytes, required %0d", tx_q.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        n_checks++;
        if (tx_q[i] !== exp[i]) begin
          n_fails++;
          $display("FAIL read_resp_byte%0d got %h, required %h", i, tx_q[i], exp[i]);
        end
      end
      for (int i = 1; i < tx_t.size(); i++) begin
        n_checks++;
        if (tx_t[i] - tx_t[i-1] <= 50 || tx_t[i] - tx_t[i-1] > 52) begin
          n_fails++;
          $display("FAIL read_busy_gap%0d start spacing %0d cycles, required 51..52", i, tx_t[i] - tx_t[i-1]);
        end
      end
    end
  endtask

  task automatic test_discard();
    int we0 = we_cycles;
    int oe0 = oe_cycles;
    logic [31:0] a = $urandom;
    logic [31:0] d = $urandom;
    byte_q_t exp = model_resp(1'b0, d);
    tx_q.delete();
    send_byte(8'hAA);
    send_byte(8'h13);
    repeat (10) @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b0 || err_o !== 2'b00) begin
      n_fails++;
      $display("FAIL discard_status busy=%b err=%b, required 0/00", busy_o, err_o);
    end
    n_checks++;
    if (we_cycles != we0 || oe_cycles != oe0 || tx_q.size() != 0) begin
      n_fails++;
      $display("FAIL discard_activity we=%0d oe=%0d tx=%0d, required 0 0 0",
               we_cycles - we0, oe_cycles - oe0, tx_q.size());
    end
    mem_data_i = d;
    send_frame(1'b0, a, 32'h0);
    wait_idle("discard_read");
    m_addr = a;
    n_checks++;
    if (oe_addr !== a || tx_q.size() != 4) begin
      n_fails++;
      $display("FAIL discard_read addr=%h bytes=%0d, required %h 4", oe_addr, tx_q.size(), a);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (tx_q[i] !== exp[i]) begin
          n_fails++;
          $display("FAIL discard_read_byte%0d got %h, required %h", i, tx_q[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 10; f++) begin
      bit          wr = 1'($urandom_range(0, 1));
      logic [31:0] a = $urandom;
      logic [31:0] d = $urandom;
      logic [31:0] rd = $urandom;
      int          we0 = we_cycles;
      int          oe0 = oe_cycles;
      byte_q_t     exp = model_resp(wr, rd);
      tx_q.delete();
      busy_hold = $urandom_range(0, 3);
      mem_data_i = rd;
      send_frame(wr, a, d);
      wait_idle("rand");
      busy_hold = 0;
      m_addr = a;
      if (wr) m_wr_data = d;
      n_checks++;
      if (we_cycles - we0 != (wr ? 1 : 0) || oe_cycles - oe0 != (wr ? 0 : RDC)) begin
        n_fails++;
        $display("FAIL rand%0d_strobes we=%0d oe=%0d, required %0d %0d", f,
                 we_cycles - we0, oe_cycles - oe0, wr ? 1 : 0, wr ? 0 : RDC);
      end
      n_checks++;
      if (mem_addr_o !== m_addr || mem_data_o !== m_wr_data) begin
        n_fails++;
        $display("FAIL rand%0d_bus_hold addr=%h data=%h, required %h %h", f,
                 mem_addr_o, mem_data_o, m_addr, m_wr_data);
      end
      n_checks++;
      if (tx_q.size() != exp.size()) begin
        n_fails++;
        $display("FAIL rand%0d_resp_len got %0d, required %0d", f, tx_q.size(), exp.size());
      end else begin
        for (int i = 0; i < exp.size(); i++) begin
          n_checks++;
          if (tx_q[i] !== exp[i]) begin
            n_fails++;
            $display("FAIL rand%0d_byte%0d got %h, required %h", f, i, tx_q[i], exp[i]);
          end
        end
      end
    end
  endtask

  task automatic test_timeout();
    int          or0;
    logic [31:0] d = $urandom;
    byte_q_t     exp = model_resp(1'b0, d);
    // Byte arriving exactly on the timeout cycle is accepted
    tx_q.delete();
    mem_data_i = d;
    send_byte(8'h52);
    send_byte(8'h00);
    send_byte(8'h00);
    repeat (TOC - 1) @(negedge clk);
    send_byte(8'h00);
    n_checks++;
    if (busy_o !== 1'b1 || err_o !== 2'b00) begin
      n_fails++;
      $display("FAIL timeout_edge_accept busy=%b err=%b, required 1/00", busy_o, err_o);
    end
    send_byte(8'h5A);
    wait_idle("timeout_edge");
    m_addr = 32'h5A000000;
    n_checks++;
    if (oe_addr !== m_addr || tx_q.size() != 4 || tx_q[0] !== exp[0] || tx_q[3] !== exp[3]) begin
      n_fails++;
      $display("FAIL timeout_edge_read addr=%h bytes=%0d, required %h 4 bytes", oe_addr, tx_q.size(), m_addr);
    end
    // Genuine timeout
    or0 = oe_runs;
    send_byte(8'h52);
    send_byte(8'h00);
    send_byte(8'h00);
    repeat (TOC - 1) @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b1) begin
      n_fails++;
      $display("FAIL timeout_early busy=%b one cycle before limit, required 1", busy_o);
    end
    @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b0 || err_o !== 2'b01) begin
      n_fails++;
      $display("FAIL timeout_fire busy=%b err=%b, required 0/01", busy_o, err_o);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (oe_runs != or0 || mem_addr_o !== m_addr) begin
      n_fails++;
      $display("FAIL timeout_no_access oe pulses=%0d addr=%h, required 0 %h", oe_runs - or0, mem_addr_o, m_addr);
    end
  endtask

  task automatic test_overrun();
    int          n = 0;
    int          or0 = oe_runs;
    logic [31:0] a = $urandom;
    logic [31:0] d = $urandom;
    byte_q_t     exp = model_resp(1'b0, d);
    tx_q.delete();
    busy_hold = 20;
    mem_data_i = d;
    send_frame(1'b0, a, 32'h0);
    while (tx_q.size() == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (tx_q.size() == 0) begin
      n_fails++;
      $display("FAIL overrun_first_start none after %0d cycles, required one", n);
    end
    send_byte(8'h57);
    wait_idle("overrun");
    busy_hold = 0;
    m_addr = a;
    n_checks++;
    if (err_o !== 2'b11) begin
      n_fails++;
      $display("FAIL overrun_flag err=%b, required 11", err_o);
    end
    n_checks++;
    if (oe_runs - or0 != 1 || tx_q.size() != 4) begin
      n_fails++;
      $display("FAIL overrun_resp_len oe pulses=%0d bytes=%0d, required 1 4", oe_runs - or0, tx_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (tx_q[i] !== exp[i]) begin
          n_fails++;
          $display("FAIL overrun_byte%0d got %h, required %h", i, tx_q[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset_in_read();
    int oe0 = oe_cycles;
    tx_q.delete();
    mem_data_i = $urandom;
    send_frame(1'b0, $urandom, 32'h0);
    n_checks++;
    if (mem_oe_n !== 1'b0) begin
      n_fails++;
      $display("FAIL rst_read_entry oe_n=%b, required 0", mem_oe_n);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_oe_n !== 1'b1 || busy_o !== 1'b0 || err_o !== 2'b00) begin
      n_fails++;
      $display("FAIL rst_read_abort oe_n=%b busy=%b err=%b, required 1/0/00", mem_oe_n, busy_o, err_o);
    end
    rst = 1'b1;
    repeat (30) @(negedge clk);
    n_checks++;
    if (tx_q.size() != 0 || oe_cycles - oe0 != 1) begin
      n_fails++;
      $display("FAIL rst_read_quiet tx=%0d oe cycles=%0d, required 0 1", tx_q.size(), oe_cycles - oe0);
    end
    n_checks++;
    if (both_low != 0) begin
      n_fails++;
      $display("FAIL strobe_overlap both strobes low %0d cycles, required 0", both_low);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_write();
    test_read_busy();
    test_discard();
    test_random_frames();
    test_timeout();
    test_overrun();
    test_reset_in_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
